// File: rtl/mux16_arbiter_pkg.sv
// mux16_arbiter_pkg: shared source encodings, default width and output-register states
package mux16_arbiter_pkg;
  localparam int DEFAULT_WIDTH = 16;
  localparam logic SRC_A = 1'b0;
  localparam logic SRC_B = 1'b1;
  typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} state_e;
endpackage

// File: rtl/mux16_arbiter_if.sv
// mux16_arbiter_if: both producer handshakes plus the consumer side of the arbiter
interface mux16_arbiter_if
  import mux16_arbiter_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH,
  parameter int CNT_W = 16
);
  logic             a_valid;
  logic [WIDTH-1:0] a_data;
  logic             a_ready;
  logic             b_valid;
  logic [WIDTH-1:0] b_data;
  logic             b_ready;
  logic             out_valid;
  logic [WIDTH-1:0] out_data;
  logic             out_ready;
  logic             out_src;
  logic [CNT_W-1:0] xfer_count;
  modport master (
    output a_valid, a_data, b_valid, b_data, out_ready,
    input  a_ready, b_ready, out_valid, out_data, out_src, xfer_count
  );
  modport slave (
    input  a_valid, a_data, b_valid, b_data, out_ready,
    output a_ready, b_ready, out_valid, out_data, out_src, xfer_count
  );
endinterface

// File: rtl/mux16_arbiter_mux16.sv
// mux16_arbiter_mux16: the shared two-input word multiplexer (sel 0 = a, 1 = b)
module mux16_arbiter_mux16
  import mux16_arbiter_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  input  logic             sel_i,
  output logic [WIDTH-1:0] y_o
);
  assign y_o = (sel_i == SRC_B) ? b_i : a_i;
endmodule

// File: rtl/mux16_arbiter.sv
// mux16_arbiter: round-robin share of one Mux16 between sources A and B into a one-word output register
module mux16_arbiter
  import mux16_arbiter_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH,
  parameter int CNT_W = 16
) (
  input  logic            clk,
  input  logic            reset,
  mux16_arbiter_if.slave  bus
);
  state_e           state_q, state_d;
  logic             last_grant_q, last_grant_d;
  logic             src_q, src_d;
  logic [WIDTH-1:0] data_q, data_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] mux_y;
  logic             free, winner, accept;
  mux16_arbiter_mux16 #(.WIDTH(WIDTH)) u_mux (
    .a_i   (bus.a_data),
    .b_i   (bus.b_data),
    .sel_i (winner),
    .y_o   (mux_y)
  );
  // With both sources valid the one not granted last wins; a lone source always wins.
  always_comb begin
    free         = (state_q == EMPTY) || bus.out_ready;
    winner       = (bus.a_valid && bus.b_valid) ? ~last_grant_q : (bus.b_valid ? SRC_B : SRC_A);
    accept       = !reset && free && (bus.a_valid || bus.b_valid);
    bus.a_ready  = accept && (winner == SRC_A);
    bus.b_ready  = accept && (winner == SRC_B);
    state_d      = accept ? FULL : (bus.out_ready ? EMPTY : state_q);
    data_d       = accept ? mux_y : data_q;
    src_d        = accept ? winner : src_q;
    last_grant_d = accept ? winner : last_grant_q;
    cnt_d        = (state_q == FULL && bus.out_ready) ? cnt_q + CNT_W'(1) : cnt_q;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= EMPTY;
      last_grant_q <= SRC_B;
      src_q        <= SRC_A;
      data_q       <= '0;
      cnt_q        <= '0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      src_q        <= src_d;
      data_q       <= data_d;
      cnt_q        <= cnt_d;
    end
  end
  assign bus.out_valid  = (state_q == FULL);
  assign bus.out_data   = data_q;
  assign bus.out_src    = src_q;
  assign bus.xfer_count = cnt_q;
endmodule

// File: tb/tb_mux16_arbiter.sv
// tb_mux16_arbiter: random and directed stimulus, reference model feeding a scoreboard checked by a monitor
module tb_mux16_arbiter;
  localparam int WIDTH = 16;
  localparam int CNT_W = 4;
  typedef struct packed {
    logic             src;
    logic [WIDTH-1:0] data;
  } item_t;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int vectors = 0;
  int miscompares = 0;
  item_t sb[$];
  logic [CNT_W-1:0] exp_cnt = '0;
  logic             m_full = 1'b0;
  logic             m_last = 1'b1;
  logic             m_src = 1'b0;
  logic [WIDTH-1:0] m_data = '0;
  mux16_arbiter_if #(.WIDTH(WIDTH), .CNT_W(CNT_W)) bus ();
  mux16_arbiter #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
    .clk   (clk),
    .reset (rst),
    .bus   (bus.slave)
  );
  always #5 clk = ~clk;
  function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endfunction
  task automatic step(input logic r, input logic av, input logic [WIDTH-1:0] ad,
                      input logic bv, input logic [WIDTH-1:0] bd, input logic ordy);
    logic win, acc;
    @(posedge clk);
    #1;
    rst = r;
    bus.a_valid = av;
    bus.a_data = ad;
    bus.b_valid = bv;
    bus.b_data = bd;
    bus.out_ready = ordy;
    #1;
    if (av && bv) win = (m_last == 1'b1) ? 1'b0 : 1'b1;
    else win = bv;
    acc = !r && (!m_full || ordy) && (av || bv);
    check("out_valid", {31'd0, bus.out_valid}, {31'd0, m_full});
    check("out_data", {16'd0, bus.out_data}, {16'd0, m_data});
    check("out_src", {31'd0, bus.out_src}, {31'd0, m_src});
    check("a_ready", {31'd0, bus.a_ready}, {31'd0, acc && !win});
    check("b_ready", {31'd0, bus.b_ready}, {31'd0, acc && win});
    if (r) begin
      m_full = 1'b0;
      m_last = 1'b1;
      m_src = 1'b0;
      m_data = '0;
      sb.delete();
    end else if (acc) begin
      m_full = 1'b1;
      m_last = win;
      m_src = win;
      m_data = win ? bd : ad;
      sb.push_back('{src: win, data: m_data});
    end else if (ordy) begin
      m_full = 1'b0;
    end
  endtask
  // Monitor: pops the scoreboard on every completed output transfer.
  always @(negedge clk) begin
    item_t it;
    check("xfer_count", {28'd0, bus.xfer_count}, {28'd0, exp_cnt});
    if (rst) exp_cnt = '0;
    else if (bus.out_valid && bus.out_ready) begin
      if (sb.size() == 0) begin
        vectors++;
        miscompares++;
        $display("FAIL sb_underflow: got transfer of %0h, expected none", bus.out_data);
      end else begin
        it = sb.pop_front();
        check("sb_data", {16'd0, bus.out_data}, {16'd0, it.data});
        check("sb_src", {31'd0, bus.out_src}, {31'd0, it.src});
      end
      exp_cnt = exp_cnt + CNT_W'(1);
    end
  end
  initial begin
    bus.a_valid = 1'b1;
    bus.a_data = '0;
    bus.b_valid = 1'b1;
    bus.b_data = '0;
    bus.out_ready = 1'b0;
    repeat (2) step(1, 1, 16'h1111, 1, 16'h2222, 1);
    step(0, 1, 16'hAAAA, 0, 16'h0000, 1);
    repeat (2) step(0, 0, 16'h0000, 0, 16'h0000, 1);
    step(1, 0, 16'h0000, 0, 16'h0000, 1);
    repeat (4) step(0, 1, 16'h1234, 1, 16'h9876, 1);
    step(0, 0, 16'h0000, 1, 16'h0FF0, 1);
    repeat (3) step(0, 1, 16'h3CC3, 1, 16'h0FF0, 0);
    step(0, 1, 16'h3CC3, 1, 16'h0FF0, 1);
    repeat (2) step(0, 0, 16'h0000, 0, 16'h0000, 1);
    step(0, 1, 16'h5555, 0, 16'h0000, 0);
    step(0, 0, 16'h0000, 0, 16'h0000, 0);
    step(1, 1, 16'h0000, 1, 16'h0000, 0);
    step(0, 1, 16'h7777, 1, 16'h8888, 1);
    repeat (2) step(0, 0, 16'h0000, 0, 16'h0000, 1);
    for (int i = 0; i < 600; i++) begin
      logic r, av, bv, o;
      r = ($urandom_range(0, 99) == 0);
      av = ($urandom_range(0, 9) < 7);
      bv = ($urandom_range(0, 9) < 7);
      o = ($urandom_range(0, 3) != 0);
      step(r, av, WIDTH'($urandom), bv, WIDTH'($urandom), o);
    end
    step(1, 0, 16'h0000, 0, 16'h0000, 1);
    for (int i = 0; i < 20; i++) step(0, 1, WIDTH'(i), 0, 16'h0000, 1);
    repeat (2) step(0, 0, 16'h0000, 0, 16'h0000, 1);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
